// File: rtl/oam_dma.sv
// OAM DMA engine: on a CPU write to the source-page register, copies LEN bytes
// from {page,8'h00} to DEST_BASE, one byte every BYTE_CYCLES clocks.
package sm83_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module oam_dma
  import sm83_pkg::*;
#(
  parameter addr_t REG_ADDR    = 16'hFF46,
  parameter addr_t DEST_BASE   = 16'hFE00,
  parameter int    LEN         = 160,
  parameter int    BYTE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cpu_wen,
  input  addr_t cpu_addr,
  input  data_t cpu_wdata,
  output data_t cpu_rdata,
  output logic  busy,
  output addr_t mem_r_addr,
  input  data_t mem_r_data,
  output logic  mem_wen,
  output addr_t mem_w_addr,
  output data_t mem_w_data
);

  localparam int SW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(BYTE_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(LEN - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state_q, state_d;
  data_t         src_hi_q, src_hi_d;
  logic [7:0]    idx_q, idx_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          trig;

  assign trig = cpu_wen && (cpu_addr == REG_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_hi_q <= 8'h00;
      idx_q    <= 8'h00;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    unique case (state_q)
      IDLE:  ;
      START: state_d = XFER;
      XFER: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (idx_q == IDX_LAST) state_d = IDLE;
          else                   idx_d   = idx_q + 8'd1;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A trigger always wins: restart from byte 0 of the new page. The write
    // decoded for this cycle still happens since mem_wen looks at current state.
    if (trig) begin
      state_d  = START;
      src_hi_d = cpu_wdata;
      idx_d    = 8'h00;
      slot_d   = '0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_wen    = (state_q == XFER) && (slot_q == SLOT_LAST);
  assign mem_r_addr = {src_hi_q, 8'h00} + addr_t'(idx_q);
  assign mem_w_addr = DEST_BASE + addr_t'(idx_q);
  assign mem_w_data = mem_r_data;
  assign cpu_rdata  = src_hi_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: three instances cover BYTE_CYCLES=1, the default
// timing, and destination wrap; write logs and OAM shadows feed the checks.
module tb_oam_dma;
  import sm83_pkg::*;

  typedef struct {
    int    e;
    addr_t ra;
    addr_t wa;
    data_t d;
  } wr_t;

  logic  clk = 1'b0;
  logic  rst_n;
  addr_t cpu_addr;
  data_t cpu_wdata;

  logic  a_cwen, b_cwen, c_cwen;
  data_t a_rdata_cpu, b_rdata_cpu, c_rdata_cpu;
  logic  a_busy, b_busy, c_busy;
  addr_t a_raddr, b_raddr, c_raddr;
  data_t a_rdata, b_rdata, c_rdata;
  logic  a_wen, b_wen, c_wen;
  addr_t a_waddr, b_waddr, c_waddr;
  data_t a_wdata, b_wdata, c_wdata;

  data_t dst_a [0:65535];
  data_t dst_b [0:65535];
  data_t dst_c [0:65535];
  wr_t   qa[$], qb[$], qc[$];
  int    edge_n = 0;
  int    bcnt_a = 0, bcnt_b = 0, bcnt_c = 0;
  int    n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic data_t src_a(input addr_t a);
    if (a[15:8] == 8'h12)      return a[7:0] ^ 8'h5A;
    else if (a[15:8] == 8'h34) return a[7:0] ^ 8'hA5;
    else                       return a[7:0];
  endfunction
  function automatic data_t src_b(input addr_t a);
    return (a[7:0] + 8'h11) ^ a[15:8];
  endfunction
  function automatic data_t src_c(input addr_t a);
    return a[7:0] + 8'h40;
  endfunction

  assign a_rdata = src_a(a_raddr);
  assign b_rdata = src_b(b_raddr);
  assign c_rdata = src_c(c_raddr);

  oam_dma #(.LEN(160), .BYTE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_wen(a_cwen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_rdata_cpu), .busy(a_busy), .mem_r_addr(a_raddr), .mem_r_data(a_rdata),
    .mem_wen(a_wen), .mem_w_addr(a_waddr), .mem_w_data(a_wdata));

  oam_dma dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_wen(b_cwen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_rdata_cpu), .busy(b_busy), .mem_r_addr(b_raddr), .mem_r_data(b_rdata),
    .mem_wen(b_wen), .mem_w_addr(b_waddr), .mem_w_data(b_wdata));

  oam_dma #(.DEST_BASE(16'hFFF0), .LEN(32), .BYTE_CYCLES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .cpu_wen(c_cwen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(c_rdata_cpu), .busy(c_busy), .mem_r_addr(c_raddr), .mem_r_data(c_rdata),
    .mem_wen(c_wen), .mem_w_addr(c_waddr), .mem_w_data(c_wdata));

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (a_wen) begin dst_a[a_waddr] <= a_wdata; qa.push_back('{edge_n, a_raddr, a_waddr, a_wdata}); end
    if (b_wen) begin dst_b[b_waddr] <= b_wdata; qb.push_back('{edge_n, b_raddr, b_waddr, b_wdata}); end
    if (c_wen) begin dst_c[c_waddr] <= c_wdata; qc.push_back('{edge_n, c_raddr, c_waddr, c_wdata}); end
    if (a_busy) bcnt_a <= bcnt_a + 1;
    if (b_busy) bcnt_b <= bcnt_b + 1;
    if (c_busy) bcnt_c <= bcnt_c + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; the trigger is sampled at the following posedge (edge t0).
  task automatic trig(input int which, input addr_t a, input data_t d, output int t0);
    t0 = edge_n;
    cpu_addr = a;
    cpu_wdata = d;
    case (which)
      0: a_cwen = 1'b1;
      1: b_cwen = 1'b1;
      default: c_cwen = 1'b1;
    endcase
    @(posedge clk);
    #1;
    a_cwen = 1'b0; b_cwen = 1'b0; c_cwen = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int bound, input string tag);
    int   n;
    logic b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      b = (which == 0) ? a_busy : (which == 1) ? b_busy : c_busy;
    end while (b && n < bound);
    chk(tag, 32'(b), 32'd0);
  endtask

  initial begin
    int t0, t1, n0, c0, errs, idx;
    addr_t ad;
    rst_n = 1'b0;
    a_cwen = 1'b0; b_cwen = 1'b0; c_cwen = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk("rst_busy_a", 32'(a_busy), 0);
    chk("rst_wen_a", 32'(a_wen), 0);
    chk("rst_rdata_b", 32'(b_rdata_cpu), 0);
    chk("rst_raddr_b", 32'(b_raddr), 0);
    chk("rst_waddr_b", 32'(b_waddr), 32'hFE00);
    chk("rst_waddr_c", 32'(c_waddr), 32'hFFF0);
    @(negedge clk); rst_n = 1'b1;

    // Non-matching address is ignored.
    @(negedge clk); trig(1, 16'hFF47, 8'h77, t0);
    repeat (5) @(negedge clk);
    chk("ign_busy", 32'(b_busy), 0);
    chk("ign_rdata", 32'(b_rdata_cpu), 0);
    chk("ign_writes", 32'(qb.size()), 0);

    // Basic copy, BYTE_CYCLES=1.
    n0 = qa.size(); c0 = bcnt_a;
    @(negedge clk); trig(0, 16'hFF46, 8'h12, t0);
    repeat (10) @(negedge clk);
    chk("basic_rdata_mid", 32'(a_rdata_cpu), 32'h12);
    chk("basic_busy_mid", 32'(a_busy), 1);
    wait_idle(0, 400, "basic_timeout");
    chk("basic_writes", qa.size() - n0, 160);
    chk("basic_busy_cycles", bcnt_a - c0, 161);
    chk("basic_first_cyc", qa[n0].e - t0, 2);
    chk("basic_last_cyc", qa[qa.size()-1].e - t0, 161);
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      ad = 16'hFE00 + 16'(k);
      if (dst_a[ad] !== (8'(k) ^ 8'h5A)) errs++;
    end
    chk("basic_data_errs", errs, 0);
    chk("basic_rdata_after", 32'(a_rdata_cpu), 32'h12);

    // Trigger on the last byte's write cycle: that write lands, busy stays high.
    n0 = qa.size(); c0 = bcnt_a;
    @(negedge clk); trig(0, 16'hFF46, 8'h12, t0);
    while (edge_n != t0 + 161) @(negedge clk);
    trig(0, 16'hFF46, 8'h12, t1);
    wait_idle(0, 600, "coin_timeout");
    chk("coin_writes", qa.size() - n0, 320);
    chk("coin_busy_cycles", bcnt_a - c0, 322);
    chk("coin_last_cyc", qa[qa.size()-1].e - t0, 322);
    idx = -1;
    for (int k = n0; k < qa.size(); k++) if (qa[k].e == t0 + 161) idx = k;
    chk("coin_lastbyte_seen", 32'(idx >= 0), 1);
    if (idx >= 0) chk("coin_lastbyte_waddr", 32'(qa[idx].wa), 32'hFE9F);

    // Restart mid-transfer.
    n0 = qa.size(); c0 = bcnt_a;
    @(negedge clk); trig(0, 16'hFF46, 8'h12, t0);
    while (edge_n != t0 + 50) @(negedge clk);
    trig(0, 16'hFF46, 8'h34, t1);
    wait_idle(0, 600, "rs_timeout");
    chk("rs_writes", qa.size() - n0, 209);
    chk("rs_busy_cycles", bcnt_a - c0, 211);
    idx = -1;
    for (int k = qa.size() - 1; k >= n0; k--) if (qa[k].e > t0 + 50) idx = k;
    chk("rs_next_cyc", qa[idx].e - t0, 52);
    chk("rs_next_raddr", 32'(qa[idx].ra), 32'h3400);
    chk("rs_next_waddr", 32'(qa[idx].wa), 32'hFE00);
    chk("rs_trigcyc_raddr", 32'(qa[idx-1].ra), 32'h1230);
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      ad = 16'hFE00 + 16'(k);
      if (dst_a[ad] !== (8'(k) ^ 8'hA5)) errs++;
    end
    chk("rs_data_errs", errs, 0);
    chk("rs_rdata", 32'(a_rdata_cpu), 32'h34);

    // Default timing, BYTE_CYCLES=4.
    n0 = qb.size(); c0 = bcnt_b;
    @(negedge clk); trig(1, 16'hFF46, 8'hC0, t0);
    repeat (20) @(negedge clk);
    chk("def_rdata_mid", 32'(b_rdata_cpu), 32'hC0);
    wait_idle(1, 900, "def_timeout");
    chk("def_writes", qb.size() - n0, 160);
    chk("def_busy_cycles", bcnt_b - c0, 641);
    chk("def_first_cyc", qb[n0].e - t0, 5);
    chk("def_first_raddr", 32'(qb[n0].ra), 32'hC000);
    chk("def_first_waddr", 32'(qb[n0].wa), 32'hFE00);
    chk("def_last_cyc", qb[qb.size()-1].e - t0, 641);
    chk("def_last_raddr", 32'(qb[qb.size()-1].ra), 32'hC09F);
    chk("def_last_waddr", 32'(qb[qb.size()-1].wa), 32'hFE9F);
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      ad = 16'hFE00 + 16'(k);
      if (dst_b[ad] !== src_b(16'hC000 + 16'(k))) errs++;
    end
    chk("def_data_errs", errs, 0);

    // Destination wrap past FFFF.
    n0 = qc.size(); c0 = bcnt_c;
    @(negedge clk); trig(2, 16'hFF46, 8'h80, t0);
    wait_idle(2, 200, "wrap_timeout");
    chk("wrap_writes", qc.size() - n0, 32);
    chk("wrap_busy_cycles", bcnt_c - c0, 65);
    chk("wrap_b16_waddr", 32'(qc[n0+16].wa), 32'h0000);
    errs = 0;
    for (int k = 0; k < 32; k++) begin
      ad = 16'hFFF0 + 16'(k);
      if (dst_c[ad] !== (8'(k) + 8'h40)) errs++;
    end
    chk("wrap_data_errs", errs, 0);

    // Async reset in the middle of a write cycle.
    n0 = qb.size();
    @(negedge clk); trig(1, 16'hFF46, 8'hC0, t0);
    while (edge_n != t0 + 101) @(negedge clk);
    chk("rst_pre_wen", 32'(b_wen), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(b_wen), 0);
    chk("rst_mid_busy", 32'(b_busy), 0);
    chk("rst_mid_rdata", 32'(b_rdata_cpu), 0);
    chk("rst_mid_raddr", 32'(b_raddr), 0);
    chk("rst_mid_waddr", 32'(b_waddr), 32'hFE00);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_post_writes", qb.size() - n0, 24);
    chk("rst_post_busy", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
